// File: rtl/instruction_queue.sv
// Circular instruction queue with head read-out, sticky overflow on dropped loads,
// and flush for branch redirects. Entry storage is never cleared, only pointers/flags.
module instruction_queue #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic [WIDTH-1:0]           in,
  input  logic                       load,
  input  logic                       advance,
  input  logic                       flush,
  output logic [WIDTH-1:0]           out,
  output logic                       out_valid,
  output logic                       full,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       overflow
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_rd;
  logic [PW-1:0]    r_wr;
  logic [CW-1:0]    r_count;
  logic             r_overflow;

  logic w_valid;
  logic w_full;
  logic w_adv_ok;
  logic w_load_ok;
  logic w_drop;

  assign w_valid   = (r_count != '0);
  assign w_full    = (r_count == CW'(DEPTH));
  assign w_adv_ok  = advance && w_valid;
  // A full queue still takes a load when the head leaves in the same cycle.
  assign w_load_ok = load && (!w_full || w_adv_ok);
  assign w_drop    = load && !w_load_ok;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_rd       <= '0;
      r_wr       <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else if (flush) begin
      r_rd       <= '0;
      r_wr       <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_adv_ok)  r_rd <= r_rd + PW'(1);
      if (w_load_ok) r_wr <= r_wr + PW'(1);
      r_count <= r_count + CW'(w_load_ok) - CW'(w_adv_ok);
      if (w_drop) r_overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset_n && !flush && w_load_ok) r_mem[r_wr] <= in;
  end

  assign out       = w_valid ? r_mem[r_rd] : '0;
  assign out_valid = w_valid;
  assign full      = w_full;
  assign count     = r_count;
  assign overflow  = r_overflow;

endmodule

// File: tb/tb_instruction_queue.sv
// Bench for instruction_queue: directed scenarios plus randomized traffic
// compared against a queue-based reference model.
module tb_instruction_queue;

  localparam int WIDTH = 16;
  localparam int DEPTH = 4;

  logic             clk = 1'b0;
  logic             reset_n;
  logic [WIDTH-1:0] in;
  logic             load;
  logic             advance;
  logic             flush;
  logic [WIDTH-1:0] out;
  logic             out_valid;
  logic             full;
  logic [2:0]       count;
  logic             overflow;

  int checks = 0;
  int errors = 0;

  logic [WIDTH-1:0] mq[$];
  logic             m_ovf = 1'b0;

  instruction_queue #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset_n(reset_n), .in(in), .load(load), .advance(advance),
    .flush(flush), .out(out), .out_valid(out_valid), .full(full),
    .count(count), .overflow(overflow)
  );

  always #5 clk = ~clk;

  // Drive one cycle, advance the reference model at the edge, sample 1 time unit later.
  task automatic step(input logic l, input logic a, input logic f, input logic rn,
                      input logic [WIDTH-1:0] d);
    logic acc_a, acc_l;
    load = l; advance = a; flush = f; reset_n = rn; in = d;
    @(posedge clk);
    if (!rn || f) begin
      mq.delete();
      m_ovf = 1'b0;
    end else begin
      acc_a = a && (mq.size() > 0);
      acc_l = l && ((mq.size() < DEPTH) || acc_a);
      if (l && !acc_l) m_ovf = 1'b1;
      if (acc_a) void'(mq.pop_front());
      if (acc_l) mq.push_back(d);
    end
    #1;
    load = 1'b0; advance = 1'b0; flush = 1'b0; reset_n = 1'b1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b1, 1'b0, 1'b0, 16'hDEAD);
      checks++; if (count !== 3'd0) begin errors++; $display("FAIL reset_count got %0d want 0", count); end
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", out_valid); end
      checks++; if (out !== 16'h0) begin errors++; $display("FAIL reset_out got %h want 0000", out); end
      checks++; if (full !== 1'b0) begin errors++; $display("FAIL reset_full got %b want 0", full); end
      checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_ovf got %b want 0", overflow); end
    end
  endtask

  task automatic test_single();
    step(1'b1, 1'b0, 1'b0, 1'b1, 16'hAAAA);
    checks++; if (out !== 16'hAAAA) begin errors++; $display("FAIL single_out got %h want aaaa", out); end
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL single_valid got %b want 1", out_valid); end
    checks++; if (count !== 3'd1) begin errors++; $display("FAIL single_count got %0d want 1", count); end
    step(1'b0, 1'b1, 1'b0, 1'b1, 16'h0);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL single_adv_valid got %b want 0", out_valid); end
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL single_adv_count got %0d want 0", count); end
    checks++; if (out !== 16'h0) begin errors++; $display("FAIL single_adv_out got %h want 0000", out); end
    // Advance while empty must be ignored.
    step(1'b0, 1'b1, 1'b0, 1'b1, 16'h0);
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL empty_adv_count got %0d want 0", count); end
  endtask

  task automatic test_fifo_wrap();
    logic [WIDTH-1:0] exp_seq [4];
    exp_seq = '{16'h0003, 16'h0004, 16'h0005, 16'h0006};
    for (int i = 1; i <= 4; i++) step(1'b1, 1'b0, 1'b0, 1'b1, WIDTH'(i));
    checks++; if (full !== 1'b1) begin errors++; $display("FAIL wrap_full got %b want 1", full); end
    checks++; if (count !== 3'd4) begin errors++; $display("FAIL wrap_count got %0d want 4", count); end
    step(1'b0, 1'b1, 1'b0, 1'b1, 16'h0);
    step(1'b0, 1'b1, 1'b0, 1'b1, 16'h0);
    step(1'b1, 1'b0, 1'b0, 1'b1, 16'h0005);
    step(1'b1, 1'b0, 1'b0, 1'b1, 16'h0006);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (out !== exp_seq[i]) begin errors++; $display("FAIL wrap_order[%0d] got %h want %h", i, out, exp_seq[i]); end
      step(1'b0, 1'b1, 1'b0, 1'b1, 16'h0);
    end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL wrap_drain_valid got %b want 0", out_valid); end
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b0, 1'b1, 16'h1100 + WIDTH'(i));
    step(1'b1, 1'b0, 1'b0, 1'b1, 16'h5555);
    checks++; if (count !== 3'd4) begin errors++; $display("FAIL ovf_count got %0d want 4", count); end
    checks++; if (out !== 16'h1100) begin errors++; $display("FAIL ovf_head got %h want 1100", out); end
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag got %b want 1", overflow); end
    for (int i = 0; i < 2; i++) begin
      step(1'b0, 1'b1, 1'b0, 1'b1, 16'h0);
      checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky[%0d] got %b want 1", i, overflow); end
    end
    // The dropped word must never surface: remaining entries are 1102, 1103.
    checks++; if (out !== 16'h1102) begin errors++; $display("FAIL ovf_after_adv got %h want 1102", out); end
    step(1'b0, 1'b0, 1'b1, 1'b1, 16'h0);
  endtask

  task automatic test_full_both();
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b0, 1'b1, 16'hA1A1 + WIDTH'(i));
    step(1'b1, 1'b1, 1'b0, 1'b1, 16'h5555);
    checks++; if (count !== 3'd4) begin errors++; $display("FAIL both_count got %0d want 4", count); end
    checks++; if (out !== 16'hA1A2) begin errors++; $display("FAIL both_head got %h want a1a2", out); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL both_ovf got %b want 0", overflow); end
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, 1'b1, 16'h0);
    checks++; if (out !== 16'h5555) begin errors++; $display("FAIL both_tail got %h want 5555", out); end
    // Load+advance on empty: load wins, count becomes 1.
    step(1'b0, 1'b1, 1'b0, 1'b1, 16'h0);
    step(1'b1, 1'b1, 1'b0, 1'b1, 16'hBEEF);
    checks++; if (count !== 3'd1) begin errors++; $display("FAIL empty_both_count got %0d want 1", count); end
    checks++; if (out !== 16'hBEEF) begin errors++; $display("FAIL empty_both_out got %h want beef", out); end
    step(1'b0, 1'b0, 1'b1, 1'b1, 16'h0);
  endtask

  task automatic test_flush();
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b0, 1'b1, 16'h3300 + WIDTH'(i));
    step(1'b0, 1'b1, 1'b0, 1'b1, 16'h0);
    checks++; if (count !== 3'd3) begin errors++; $display("FAIL flush_pre_count got %0d want 3", count); end
    step(1'b1, 1'b1, 1'b1, 1'b1, 16'h7777);
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL flush_count got %0d want 0", count); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_valid got %b want 0", out_valid); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL flush_ovf got %b want 0", overflow); end
    checks++; if (out !== 16'h0) begin errors++; $display("FAIL flush_out got %h want 0000", out); end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b0, 1'b1, 16'h4400 + WIDTH'(i));
    step(1'b0, 1'b1, 1'b0, 1'b1, 16'h0);
    step(1'b0, 1'b1, 1'b0, 1'b1, 16'h0);
    checks++; if (count !== 3'd2 || overflow !== 1'b1) begin
      errors++; $display("FAIL rmid_pre got count %0d ovf %b want 2 1", count, overflow);
    end
    step(1'b1, 1'b1, 1'b1, 1'b0, 16'h9999);
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL rmid_count got %0d want 0", count); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL rmid_ovf got %b want 0", overflow); end
    checks++; if (out !== 16'h0) begin errors++; $display("FAIL rmid_out got %h want 0000", out); end
    step(1'b1, 1'b0, 1'b0, 1'b1, 16'h1234);
    checks++; if (out !== 16'h1234) begin errors++; $display("FAIL rmid_load got %h want 1234", out); end
    checks++; if (count !== 3'd1) begin errors++; $display("FAIL rmid_load_count got %0d want 1", count); end
  endtask

  task automatic test_random();
    logic l, a, f, rn;
    logic [WIDTH-1:0] d, exp_out;
    for (int n = 0; n < 600; n++) begin
      l  = ($urandom_range(0, 99) < 60);
      a  = ($urandom_range(0, 99) < 45);
      f  = ($urandom_range(0, 99) < 3);
      rn = ($urandom_range(0, 99) >= 2);
      d  = WIDTH'($urandom);
      step(l, a, f, rn, d);
      exp_out = (mq.size() > 0) ? mq[0] : '0;
      checks++;
      if (count !== 3'(mq.size()) || out !== exp_out || out_valid !== (mq.size() > 0) ||
          full !== (mq.size() == DEPTH) || overflow !== m_ovf) begin
        errors++;
        $display("FAIL rand[%0d] got cnt %0d out %h vld %b full %b ovf %b want cnt %0d out %h vld %b full %b ovf %b",
                 n, count, out, out_valid, full, overflow, mq.size(), exp_out,
                 (mq.size() > 0), (mq.size() == DEPTH), m_ovf);
      end
    end
  endtask

  initial begin
    reset_n = 1'b0; load = 1'b0; advance = 1'b0; flush = 1'b0; in = '0;
    test_reset();
    test_single();
    test_fifo_wrap();
    test_overflow();
    test_full_both();
    test_flush();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/instruction_queue.md
INSTRUCTION_QUEUE -- requirements
Module: instruction_queue

Interface
REQ-001 SHALL have parameter WIDTH, default 16, meaning instruction word width in bits (valid range 8..64).
REQ-002 SHALL have parameter DEPTH, default 4, meaning number of instruction entries (power of two, valid range 2..16).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port reset_n  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port in  input  WIDTH  instruction word to enqueue.
REQ-006 SHALL have port load  input  1  enqueue request for `in` this cycle.
REQ-007 SHALL have port advance  input  1  dequeue request for the head entry this cycle.
REQ-008 SHALL have port flush  input  1  discard all entries (branch redirect).
REQ-009 SHALL have port out  output  WIDTH  head instruction word.
REQ-010 SHALL have port out_valid  output  1  head entry holds a valid instruction.
REQ-011 SHALL have port full  output  1  count equals DEPTH.
REQ-012 SHALL have port count  output  $clog2(DEPTH)+1  number of valid entries.
REQ-013 SHALL have port overflow  output  1  sticky flag: a load was dropped.

Function
REQ-014 SHALL implement a circular buffer of DEPTH entries with read and write pointers of $clog2(DEPTH) bits each, wrapping from DEPTH-1 to 0.
REQ-015 SHALL drive out combinationally from entry[rd_ptr]; out SHALL equal 0 when out_valid is 0.
REQ-016 SHALL drive out_valid = (count != 0) and full = (count == DEPTH), both combinational from count.
REQ-017 SHALL accept a load when count < DEPTH: write `in` to entry[wr_ptr], increment wr_ptr; the word becomes visible on `out` one cycle after the accepting edge if the queue was empty (latency 1).
REQ-018 SHALL accept an advance when count != 0: increment rd_ptr; an advance while empty SHALL be ignored with no state change.
REQ-019 SHALL accept load and advance together when full: the dequeue and enqueue both occur and count stays DEPTH.
REQ-020 SHALL accept load and advance together when empty: the load is accepted, the advance ignored, count becomes 1.
REQ-021 SHALL update count = count + load_accepted - advance_accepted each cycle; count SHALL never exceed DEPTH or go below 0.
REQ-022 SHALL drop a load when full and advance is 0: no entry written, pointers and count unchanged, overflow set to 1 at the next edge.
REQ-023 SHALL hold overflow at 1 until reset or flush.
REQ-024 SHALL give flush priority over load and advance: on a flush edge rd_ptr, wr_ptr and count become 0, overflow becomes 0, and a simultaneous load SHALL be discarded.
REQ-025 SHALL not clear entry storage on flush or reset; only pointers, count and flags are cleared.

Reset
REQ-026 SHALL, on a rising clk edge with reset_n = 0, set rd_ptr = 0, wr_ptr = 0, count = 0 and overflow = 0, so that out = 0, out_valid = 0 and full = 0.
REQ-027 SHALL give reset priority over flush, load and advance; reset asserted mid-operation SHALL discard all queued entries at that edge.
REQ-028 SHALL hold all state with no outputs changing when reset_n = 0 for multiple cycles.

Verification
REQ-029 Bench SHALL cover single load/advance: reset, load 16'hAAAA for one cycle -> out = 16'hAAAA, out_valid = 1, count = 1 after that edge; advance for one cycle -> out_valid = 0, count = 0.
REQ-030 Bench SHALL cover FIFO order and wrap: load 16'h0001..16'h0004 -> full = 1; advance twice, load 16'h0005, 16'h0006 -> out sequence on successive advances is 0003, 0004, 0005, 0006.
REQ-031 Bench SHALL cover overflow: with the queue full, load 16'h5555 with advance = 0 -> count = 4, head unchanged, overflow = 1; overflow stays 1 across subsequent advances.
REQ-032 Bench SHALL cover simultaneous full load+advance: with the queue full, load 16'h5555 with advance = 1 -> count stays 4, head moves to the 2nd entry, 16'h5555 appears at the tail.
REQ-033 Bench SHALL cover flush vs load: with 3 entries queued, flush = 1 and load = 1 in the same cycle -> count = 0, out_valid = 0, overflow = 0.
REQ-034 Bench SHALL cover reset mid-operation: with 2 entries queued and overflow = 1, reset_n = 0 for one edge -> count = 0, overflow = 0, out = 0; the next load of 16'h1234 appears on out one cycle later.
